// File: rtl/sd_cmd_serial_host.sv
// SD command-path host: serialises a CRC7-protected 48-bit command, then optionally captures and checks a short/long response.
// Build option SD_CMD_R3_NOCRC_EN: short responses carrying index 6'h3F (R3/OCR) bypass the CRC compare.
module sd_cmd_serial_host #(
    parameter int unsigned TIMEOUT_BITS = 64,
    parameter int unsigned TURN_BITS    = 2
) (
    input  logic        sd_clk_i,
    input  logic        sd_rst_n_i,
    input  logic        sd_ce_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [1:0]  wait_resp_i,
    input  logic [31:0] arg_i,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe,
    output logic        busy_o,
    output logic        cmd_sent_o,
    output logic        cmd_rend_o,
    output logic        ccrc_fail_o,
    output logic        ctimeout_o,
    output logic [5:0]  resp_index_o,
    output logic [31:0] resp1_o,
    output logic [31:0] resp2_o,
    output logic [31:0] resp3_o,
    output logic [31:0] resp4_o
);

    localparam int unsigned FRAME_W = 48;
    localparam int unsigned SHIFT_W = 128;
    localparam int unsigned CNT_W   = (TIMEOUT_BITS > 255) ? $clog2(TIMEOUT_BITS) + 1 : 8;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_TURN, S_WAIT, S_RECV, S_CHECK, S_DONE
    } state_t;

    // Serial CRC7 (x^7+x^3+1, init 0); leading zeros do not disturb it, so shorter fields are right-aligned.
    function automatic logic [6:0] crc7(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    state_t               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_frame, w_frame_nxt;
    logic [SHIFT_W-1:0]   r_shift, w_shift_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_expect, w_expect_nxt;
    logic                 r_long, w_long_nxt;
    logic                 r_cmd, w_cmd_nxt;
    logic                 r_oe, w_oe_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_sent, w_sent_nxt;
    logic                 r_rend, w_rend_nxt;
    logic                 r_fail, w_fail_nxt;
    logic                 r_tout, w_tout_nxt;
    logic [5:0]           r_resp_index, w_idx_nxt;
    logic [31:0]          r_resp1, r_resp2, r_resp3, r_resp4;
    logic [31:0]          w_r1_nxt, w_r2_nxt, w_r3_nxt, w_r4_nxt;

    logic [6:0]           w_crc_frame;
    logic [6:0]           w_crc_resp;
    logic                 w_crc_bypass;
    logic                 w_resp_ok;

    assign w_crc_frame = crc7({80'b0, 2'b01, cmd_index_i, arg_i});
    assign w_crc_resp  = r_long ? crc7(r_shift[127:8]) : crc7({80'b0, r_shift[47:8]});

`ifdef SD_CMD_R3_NOCRC_EN
    assign w_crc_bypass = !r_long && (r_shift[45:40] == 6'h3F);
`else
    assign w_crc_bypass = 1'b0;
`endif

    assign w_resp_ok = r_shift[0] && (w_crc_bypass || (w_crc_resp == r_shift[7:1]));

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_nxt  = r_frame;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_expect_nxt = r_expect;
        w_long_nxt   = r_long;
        w_cmd_nxt    = r_cmd;
        w_oe_nxt     = r_oe;
        w_sent_nxt   = 1'b0;
        w_rend_nxt   = 1'b0;
        w_fail_nxt   = 1'b0;
        w_tout_nxt   = 1'b0;
        w_idx_nxt    = r_resp_index;
        w_r1_nxt     = r_resp1;
        w_r2_nxt     = r_resp2;
        w_r3_nxt     = r_resp3;
        w_r4_nxt     = r_resp4;

        if (abort_i) begin
            w_state_nxt = S_IDLE;
            w_cmd_nxt   = 1'b1;
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_frame_nxt  = {2'b01, cmd_index_i, arg_i, w_crc_frame, 1'b1};
                        w_expect_nxt = wait_resp_i[0];
                        w_long_nxt   = wait_resp_i[1];
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_SEND;
                    end
                end
                S_SEND: begin
                    if (sd_ce_i) begin
                        w_oe_nxt    = 1'b1;
                        w_cmd_nxt   = r_frame[FRAME_W-1];
                        w_frame_nxt = {r_frame[FRAME_W-2:0], 1'b0};
                        if (r_cnt == CNT_W'(FRAME_W - 1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = r_expect ? S_TURN : S_DONE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_TURN: begin
                    if (sd_ce_i) begin
                        w_cmd_nxt = 1'b1;
                        if (r_cnt == CNT_W'(TURN_BITS - 1)) begin
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_WAIT;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (sd_ce_i) begin
                        if (!cmd_i) begin
                            w_shift_nxt = '0;
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = S_RECV;
                        end else if (r_cnt == CNT_W'(TIMEOUT_BITS - 1)) begin
                            w_cnt_nxt   = '0;
                            w_tout_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_RECV: begin
                    if (sd_ce_i) begin
                        w_shift_nxt = {r_shift[SHIFT_W-2:0], cmd_i};
                        if (r_cnt == (r_long ? CNT_W'(135) : CNT_W'(47))) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_CHECK;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (r_long) begin
                        w_idx_nxt = 6'h3F;
                        w_r1_nxt  = r_shift[127:96];
                        w_r2_nxt  = r_shift[95:64];
                        w_r3_nxt  = r_shift[63:32];
                        w_r4_nxt  = {r_shift[31:1], 1'b0};
                    end else begin
                        w_idx_nxt = r_shift[45:40];
                        w_r1_nxt  = r_shift[39:8];
                    end
                    w_rend_nxt  = w_resp_ok;
                    w_fail_nxt  = !w_resp_ok;
                    w_state_nxt = S_IDLE;
                end
                S_DONE: begin
                    w_sent_nxt  = 1'b1;
                    w_cmd_nxt   = 1'b1;
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge sd_clk_i or negedge sd_rst_n_i) begin
        if (!sd_rst_n_i) begin
            r_state      <= S_IDLE;
            r_frame      <= '0;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_expect     <= 1'b0;
            r_long       <= 1'b0;
            r_cmd        <= 1'b1;
            r_oe         <= 1'b0;
            r_busy       <= 1'b0;
            r_sent       <= 1'b0;
            r_rend       <= 1'b0;
            r_fail       <= 1'b0;
            r_tout       <= 1'b0;
            r_resp_index <= '0;
            r_resp1      <= '0;
            r_resp2      <= '0;
            r_resp3      <= '0;
            r_resp4      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame      <= w_frame_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_expect     <= w_expect_nxt;
            r_long       <= w_long_nxt;
            r_cmd        <= w_cmd_nxt;
            r_oe         <= w_oe_nxt;
            r_busy       <= w_busy_nxt;
            r_sent       <= w_sent_nxt;
            r_rend       <= w_rend_nxt;
            r_fail       <= w_fail_nxt;
            r_tout       <= w_tout_nxt;
            r_resp_index <= w_idx_nxt;
            r_resp1      <= w_r1_nxt;
            r_resp2      <= w_r2_nxt;
            r_resp3      <= w_r3_nxt;
            r_resp4      <= w_r4_nxt;
        end
    end

    assign cmd_o        = r_cmd;
    assign cmd_oe       = r_oe;
    assign busy_o       = r_busy;
    assign cmd_sent_o   = r_sent;
    assign cmd_rend_o   = r_rend;
    assign ccrc_fail_o  = r_fail;
    assign ctimeout_o   = r_tout;
    assign resp_index_o = r_resp_index;
    assign resp1_o      = r_resp1;
    assign resp2_o      = r_resp2;
    assign resp3_o      = r_resp3;
    assign resp4_o      = r_resp4;

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// Scoreboard bench for sd_cmd_serial_host: expected frames/status are queued by the stimulus, popped by monitors.
module tb_sd_cmd_serial_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sd_ce;
    logic        start;
    logic        abort;
    logic [5:0]  cmd_index;
    logic [1:0]  wait_resp;
    logic [31:0] arg;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        cmd_sent;
    logic        cmd_rend;
    logic        ccrc_fail;
    logic        ctimeout;
    logic [5:0]  resp_index;
    logic [31:0] resp1, resp2, resp3, resp4;

    always #5 clk = ~clk;

    sd_cmd_serial_host dut (
        .sd_clk_i     (clk),
        .sd_rst_n_i   (rst_n),
        .sd_ce_i      (sd_ce),
        .start_i      (start),
        .abort_i      (abort),
        .cmd_index_i  (cmd_index),
        .wait_resp_i  (wait_resp),
        .arg_i        (arg),
        .cmd_i        (cmd_in),
        .cmd_o        (cmd_out),
        .cmd_oe       (cmd_oe),
        .busy_o       (busy),
        .cmd_sent_o   (cmd_sent),
        .cmd_rend_o   (cmd_rend),
        .ccrc_fail_o  (ccrc_fail),
        .ctimeout_o   (ctimeout),
        .resp_index_o (resp_index),
        .resp1_o      (resp1),
        .resp2_o      (resp2),
        .resp3_o      (resp3),
        .resp4_o      (resp4)
    );

    localparam int K_SENT = 0, K_REND = 1, K_FAIL = 2, K_TOUT = 3;

    typedef struct {
        int          kind;
        logic [5:0]  idx;
        logic [31:0] r1, r2, r3, r4;
        bit          lng;
    } st_t;

    st_t         sq[$];
    logic [47:0] fq[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Division-style CRC7 reference: message*x^7 mod 0x89 over d[n-1:0]
    function automatic logic [6:0] crc_model(input logic [135:0] d, input int n);
        int r;
        r = 0;
        for (int i = n - 1; i >= -7; i--) begin
            r = (r << 1) | ((i >= 0) ? int'(d[i]) : 0);
            if ((r & 32'h80) != 0) r = r ^ 32'h89;
        end
        return 7'(r);
    endfunction

    task automatic push_st(input int kind, input logic [5:0] idx, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3, input logic [31:0] r4,
                           input bit lng);
        st_t e;
        e.kind = kind; e.idx = idx; e.r1 = r1; e.r2 = r2; e.r3 = r3; e.r4 = r4; e.lng = lng;
        sq.push_back(e);
    endtask

    // Bit strobe: high every other clock
    initial begin
        sd_ce = 1'b0;
        forever begin
            @(negedge clk);
            sd_ce = ~sd_ce;
        end
    end

    // Frame monitor: collects 48 driven bits starting at the output-enable rising edge
    initial begin : frame_mon
        logic        prev_oe, coll, ce_at;
        logic [47:0] bits, e;
        int          nb;
        prev_oe = 1'b0; coll = 1'b0; bits = '0; nb = 0;
        forever begin
            @(posedge clk);
            ce_at = sd_ce;
            #1;
            if (coll && !cmd_oe) begin
                coll = 1'b0;
            end else if (coll && ce_at) begin
                bits = {bits[46:0], cmd_out};
                nb++;
                if (nb == 48) begin
                    coll = 1'b0;
                    if (fq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL frame_unexpected: got %0h, expected none", bits);
                    end else begin
                        e = fq.pop_front();
                        chk("frame", 128'(bits), 128'(e));
                    end
                end
            end else if (!coll && cmd_oe && !prev_oe) begin
                coll = 1'b1;
                bits = {47'b0, cmd_out};
                nb   = 1;
            end
            prev_oe = cmd_oe;
        end
    end

    // Status monitor: one pulse at a time, compared against the scoreboard
    initial begin : status_mon
        int  np, kind;
        st_t e;
        forever begin
            @(negedge clk);
            np = int'(cmd_sent) + int'(cmd_rend) + int'(ccrc_fail) + int'(ctimeout);
            if (np > 1) begin
                n_cmp++; n_err++;
                $display("FAIL pulse_exclusive: got %0d pulses, expected 1", np);
            end
            if (np >= 1) begin
                kind = cmd_sent ? K_SENT : cmd_rend ? K_REND : ccrc_fail ? K_FAIL : K_TOUT;
                if (sq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL status_unexpected: got kind %0d, expected none", kind);
                end else begin
                    e = sq.pop_front();
                    chk("status_kind", 128'(kind), 128'(e.kind));
                    if (e.kind == K_REND || e.kind == K_FAIL) begin
                        chk("resp_index", 128'(resp_index), 128'(e.idx));
                        chk("resp1", 128'(resp1), 128'(e.r1));
                        if (e.lng) begin
                            chk("resp2", 128'(resp2), 128'(e.r2));
                            chk("resp3", 128'(resp3), 128'(e.r3));
                            chk("resp4", 128'(resp4), 128'(e.r4));
                        end
                    end
                end
            end
        end
    end

    task automatic issue_start(input logic [5:0] idx, input logic [31:0] a, input logic [1:0] w);
        @(negedge clk);
        cmd_index = idx; arg = a; wait_resp = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_release(output bit ok);
        int k;
        k = 0;
        while (!cmd_oe && k < 2000) begin @(negedge clk); k++; end
        while (cmd_oe && k < 2000) begin @(negedge clk); k++; end
        ok = (k < 2000);
        chk("release_seen", 128'(ok), 128'(1));
    endtask

    // Card model: idle high for dly strobes after release, then len bits MSB first
    task automatic card_respond(input logic [135:0] b, input int len, input int dly);
        bit   ok;
        logic ce_at;
        int   n;
        wait_release(ok);
        if (!ok) return;
        n = 0;
        while (n < dly + len) begin
            @(posedge clk);
            ce_at = sd_ce;
            #1;
            if (ce_at) begin
                n++;
                if (n >= dly && n < dly + len) cmd_in = b[len - 1 - (n - dly)];
                else if (n == dly + len) cmd_in = 1'b1;
            end
        end
        cmd_in = 1'b1;
    endtask

    task automatic count_timeout();
        bit   ok, seen;
        logic ce_at;
        int   n, k;
        wait_release(ok);
        n = 0; k = 0; seen = 1'b0;
        while (!seen && k < 1000) begin
            @(posedge clk);
            ce_at = sd_ce;
            @(negedge clk);
            if (ce_at) n++;
            seen = ctimeout;
            k++;
        end
        chk("timeout_seen", 128'(seen), 128'(1));
        chk("timeout_strobes", 128'(n), 128'(64));
    endtask

    task automatic stop_at_bit20();
        int n;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            if (sd_ce) n++;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [119:0] cid;
        logic [6:0]   c;
        logic [135:0] lb;
        logic [47:0]  r3;
        int           k3;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cmd_index = '0; wait_resp = '0;
        arg = '0; cmd_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_o", 128'(cmd_out), 128'(1));
        chk("rst_cmd_oe", 128'(cmd_oe), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_pulses", 128'({cmd_sent, cmd_rend, ccrc_fail, ctimeout}), 128'(0));
        chk("rst_resp_index", 128'(resp_index), 128'(0));
        chk("rst_resp", {resp1, resp2, resp3, resp4}, 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0, no response
        fq.push_back(48'h400000000095);
        push_st(K_SENT, 0, 0, 0, 0, 0, 0);
        issue_start(6'd0, 32'h0, 2'b00);
        wait_idle();
        chk("cmd0_oe", 128'(cmd_oe), 128'(0));
        chk("cmd0_cmd_o", 128'(cmd_out), 128'(1));

        // CMD8, short response, good CRC
        fq.push_back(48'h48000001AA87);
        push_st(K_REND, 6'h08, 32'h000001AA, 0, 0, 0, 0);
        issue_start(6'd8, 32'h000001AA, 2'b01);
        card_respond({88'b0, 48'h08000001AA13}, 48, 5);
        wait_idle();

        // CMD8, short response, corrupted CRC
        fq.push_back(48'h48000001AA87);
        push_st(K_FAIL, 6'h08, 32'h000001AA, 0, 0, 0, 0);
        issue_start(6'd8, 32'h000001AA, 2'b01);
        card_respond({88'b0, 48'h08000001AA11}, 48, 5);
        wait_idle();

        // CMD17, silent card
        fq.push_back(48'h510000000055);
        push_st(K_TOUT, 0, 0, 0, 0, 0, 0);
        issue_start(6'd17, 32'h0, 2'b01);
        count_timeout();
        wait_idle();
        chk("tout_keeps_resp1", 128'(resp1), 128'(32'h000001AA));
        chk("tout_keeps_index", 128'(resp_index), 128'(6'h08));
        chk("tout_oe", 128'(cmd_oe), 128'(0));

        // CMD2, long response
        cid = 120'h0123456789ABCDEFFEDCBA98765432;
        c   = crc_model({16'b0, cid}, 120);
        lb  = {8'h3F, cid, c, 1'b1};
        c   = crc_model({88'b0, 48'h420000000000} >> 8, 40);
        fq.push_back({40'h4200000000, c, 1'b1});
        push_st(K_REND, 6'h3F, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, {24'h765432, lb[7:1], 1'b0}, 1);
        issue_start(6'd2, 32'h0, 2'b11);
        card_respond(lb, 136, 3);
        wait_idle();

        // R3-style response: index field 3F, CRC field all ones
        r3 = 48'h3F00FF8000FF;
`ifdef SD_CMD_R3_NOCRC_EN
        k3 = K_REND;
`else
        k3 = (crc_model({88'b0, r3} >> 8, 40) == 7'h7F) ? K_REND : K_FAIL;
`endif
        c = crc_model({96'b0, 2'b01, 6'd41, 32'h40FF8000}, 40);
        fq.push_back({2'b01, 6'd41, 32'h40FF8000, c, 1'b1});
        push_st(k3, 6'h3F, 32'h00FF8000, 0, 0, 0, 0);
        issue_start(6'd41, 32'h40FF8000, 2'b01);
        card_respond({88'b0, r3}, 48, 2);
        wait_idle();

        // Reset at bit 20 of SEND, then a normal command
        issue_start(6'd17, 32'h0, 2'b01);
        stop_at_bit20();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", 128'(cmd_oe), 128'(0));
        chk("rst_mid_cmd_o", 128'(cmd_out), 128'(1));
        chk("rst_mid_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fq.push_back(48'h400000000095);
        push_st(K_SENT, 0, 0, 0, 0, 0, 0);
        issue_start(6'd0, 32'h0, 2'b00);
        wait_idle();

        // Abort at bit 20 of SEND, then a normal command
        issue_start(6'd17, 32'h0, 2'b01);
        stop_at_bit20();
        @(negedge clk);
        abort = 1'b1;
        chk("abort_pending_busy", 128'(busy), 128'(1));
        @(negedge clk);
        abort = 1'b0;
        chk("abort_oe", 128'(cmd_oe), 128'(0));
        chk("abort_cmd_o", 128'(cmd_out), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        repeat (4) @(negedge clk);
        fq.push_back(48'h400000000095);
        push_st(K_SENT, 0, 0, 0, 0, 0, 0);
        issue_start(6'd0, 32'h0, 2'b00);
        wait_idle();

        repeat (4) @(negedge clk);
        chk("sb_status_left", 128'(sq.size()), 128'(0));
        chk("sb_frame_left", 128'(fq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_serial_host.md
Name: sd_cmd_serial_host

Overview:
- Command-path state machine inside sd_top. Sits between the register block (SDIO_CMD/SDIO_ARG/SDIO_RESPx/SDIO_STA) and the sd_cmd pad.
- Serialises a 48-bit command frame with CRC7 and releases the line. Optionally captures a 48-bit short or 136-bit long response, checks it, and reports status pulses.
- Runs in the sd_clk_i domain. Bit timing is paced by a clock-enable strobe from the clock divider, so one bit equals one sd_ce_i.

Parameters:
- TIMEOUT_BITS, 64, number of sd_ce_i strobes to wait for a response start bit after line release (NCR window).
- TURN_BITS, 2, sd_ce_i strobes between the end bit and line release / start of response search.

Ports:
- sd_clk_i  in  1  controller SD clock.
- sd_rst_n_i  in  1  asynchronous active-low reset.
- sd_ce_i  in  1  bit strobe; one bit is shifted or sampled per strobe.
- start_i  in  1  single-cycle pulse; accepted only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE.
- cmd_index_i  in  6  command index (SDIO_CMD[5:0]).
- wait_resp_i  in  2  00/10 = none, 01 = short (48 bits), 11 = long (136 bits).
- arg_i  in  32  command argument.
- cmd_i  in  1  sampled sd_cmd pad.
- cmd_o  out  1  driven sd_cmd value.
- cmd_oe  out  1  pad output enable.
- busy_o  out  1  high in any state other than IDLE (CMDACT).
- cmd_sent_o  out  1  pulse: command sent, no response expected.
- cmd_rend_o  out  1  pulse: response received, CRC OK.
- ccrc_fail_o  out  1  pulse: response received, CRC or end bit bad.
- ctimeout_o  out  1  pulse: no start bit within TIMEOUT_BITS.
- resp_index_o  out  6  response command-index field (short) or 6'h3F (long).
- resp1_o..resp4_o  out  32 each  response words.

Behaviour:
- Reset (asynchronous, any state): state IDLE, cmd_o=1, cmd_oe=0, busy_o=0, all pulses 0, resp_index_o=0, resp1-4=0.
- All status pulses are exactly one sd_clk_i cycle wide and mutually exclusive.
- IDLE:
  - On start_i, latch the frame {0, 1, index, arg, crc7, 1}. CRC7 uses polynomial x^7+x^3+1, init 0, over the first 40 bits.
  - Go to SEND. start_i in any other state is ignored.
- SEND:
  - On each sd_ce_i, cmd_oe=1 and cmd_o=next bit, MSB first. The start bit appears at the first sd_ce_i after acceptance.
  - After the 48th bit:
    - If no response is expected, go to DONE with cmd_sent_o.
    - Otherwise go to TURN.
- TURN:
  - Drive cmd_o=1 for TURN_BITS strobes, then cmd_oe=0.
  - Go to WAIT_START and clear the timeout counter.
- WAIT_START:
  - On each sd_ce_i, sample cmd_i. A sample of 0 is the start bit: go to RECV with the bit counter at 1.
  - If the counter reaches TIMEOUT_BITS without a start bit, go to IDLE with ctimeout_o. Response registers are unchanged.
- RECV:
  - Shift cmd_i into a 136-bit register on each sd_ce_i until 48 or 136 bits are captured. Then go to CHECK.
- CHECK (one cycle, no sd_ce_i needed):
  - Short response: CRC7 over bits 47..8 must equal bits 7..1, and bit 0 must be 1.
  - Long response: CRC7 over bits 127..8 must equal bits 7..1, and bit 0 must be 1.
  - Register updates are made regardless of pass or fail:
    - Short response: resp_index_o=bits 45..40, resp1_o=bits 39..8.
    - Long response: resp1..4 = bits 127..96, 95..64, 63..32, 31..0 (bit 0 is forced 0 in resp4). resp_index_o=6'h3F.
  - Pulse cmd_rend_o or ccrc_fail_o, then go to IDLE.
- DONE: one cycle, then IDLE. busy_o falls on the same edge as the status pulse.
- abort_i, in any state, takes effect next cycle:
  - IDLE, cmd_oe=0, cmd_o=1, no status pulse.
  - abort_i has priority over start_i.
- sd_ce_i low: the state machine holds in every state except CHECK and DONE.

Optional Feature:
- SD_CMD_R3_NOCRC_EN.
- Defined: in CHECK, a short response whose index field is 6'h3F (R3/OCR) skips the CRC compare. It reports cmd_rend_o when the end bit is 1, and ccrc_fail_o otherwise.
- Undefined: every short response is CRC-checked, so an R3 response reports ccrc_fail_o.

Test Plan:
- CMD0, arg 0, wait_resp=00 -> cmd_o carries 0x400000000095 over 48 strobes. cmd_sent_o fires once, busy_o ends low, cmd_oe=0.
- CMD8, arg 0x000001AA, short response; model returns 0x08000001AA13 after 5 strobes -> frame 0x48000001AA87. cmd_rend_o fires, resp_index_o=6'h08, resp1_o=0x000001AA.
- Same as the CMD8 case, but the model returns 0x08000001AA11 (bad CRC) -> ccrc_fail_o fires, resp1_o=0x000001AA.
- CMD17, arg 0, short response; card stays silent -> frame 0x510000000055. ctimeout_o fires exactly TIMEOUT_BITS strobes after release.
- CMD2, long response; model sends 136 bits with a valid CRC -> cmd_rend_o fires, resp_index_o=6'h3F, and resp1..4 match the model payload.
- Reset and abort mid-frame, each at bit 20 of SEND:
  - Assert sd_rst_n_i low -> immediate cmd_oe=0, cmd_o=1, IDLE.
  - Pulse abort_i instead -> same result one cycle later, with no status pulse.
  - A subsequent start_i is accepted normally in both cases.
